// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Assembles a valid/ready byte stream into a WORDS x WORD_BITS
//               image for the cpu, holding the cpu in reset while loading.
//               Reports word count, XOR checksum and a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int WORDS     = 256,
    parameter int WORD_BITS = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [7:0]                          in_byte,
    input  logic                                in_valid,
    input  logic                                in_last,
    output logic                                in_ready,
    output logic [0:WORDS-1][0:WORD_BITS-1]     ex_data,
    output logic                                cpu_rst,
    output logic                                loading,
    output logic                                done,
    output logic [$clog2(WORDS):0]              word_count,
    output logic [7:0]                          checksum,
    output logic                                overflow
);

    localparam int BPW    = WORD_BITS / 8;
    localparam int C_BI_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int C_AW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int C_PW   = $clog2(WORDS) + 1;

    localparam logic [C_BI_W-1:0] C_BI_LAST = C_BI_W'(BPW - 1);
    localparam logic [C_PW-1:0]   C_WORDS   = C_PW'(WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                             r_state;
    state_t                             w_next;
    logic [0:WORDS-1][0:WORD_BITS-1]    r_ex_data;
    logic [C_BI_W-1:0]                  r_bi;
    logic [C_PW-1:0]                    r_wp;
    logic [C_PW-1:0]                    r_word_count;
    logic [7:0]                         r_checksum;
    logic                               r_overflow;

    logic                               w_start;
    logic                               w_accept;
    logic                               w_store;
    logic                               w_bi_wrap;

    assign w_start   = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
    assign w_accept  = (r_state == S_LOAD) && in_valid;
    assign w_store   = w_accept && (r_wp < C_WORDS);
    assign w_bi_wrap = (r_bi == C_BI_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode: a load ends on any accepted last beat, stored or dropped
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD:  if (w_accept && in_last) w_next = S_DONE;
            S_DONE:  if (start) w_next = S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    // Image assembly, counters and checksum; a start clears the previous image
    always_ff @(posedge clk) begin
        if (!rst || w_start) begin
            r_ex_data    <= '0;
            r_bi         <= '0;
            r_wp         <= '0;
            r_word_count <= '0;
            r_checksum   <= '0;
            r_overflow   <= 1'b0;
        end else if (w_accept) begin
            if (w_store) begin
                r_ex_data[r_wp[C_AW-1:0]][8*r_bi +: 8] <= in_byte;
                r_checksum <= r_checksum ^ in_byte;
                if (w_bi_wrap) begin
                    r_bi <= '0;
                    r_wp <= r_wp + 1'b1;
                end else begin
                    r_bi <= r_bi + 1'b1;
                end
                // A completed word and a trailing partial word each count once
                if (w_bi_wrap || in_last) begin
                    r_word_count <= r_word_count + 1'b1;
                end
            end else begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Outputs come straight from registers or the state decode
    always_comb begin
        in_ready   = (r_state == S_LOAD);
        loading    = (r_state == S_LOAD);
        done       = (r_state == S_DONE);
        cpu_rst    = (r_state == S_DONE);
        ex_data    = r_ex_data;
        word_count = r_word_count;
        checksum   = r_checksum;
        overflow   = r_overflow;
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Scoreboard bench for program_loader. Expected load results
//               are queued at load start and checked when done rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [7:0]             in_byte;
    logic                   in_valid;
    logic                   in_last;
    logic                   in_ready;
    logic [0:255][0:63]     ex_data;
    logic                   cpu_rst;
    logic                   loading;
    logic                   done;
    logic [8:0]             word_count;
    logic [7:0]             checksum;
    logic                   overflow;

    program_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .ex_data    (ex_data),
        .cpu_rst    (cpu_rst),
        .loading    (loading),
        .done       (done),
        .word_count (word_count),
        .checksum   (checksum),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] wc;
        logic [7:0] cs;
        logic       ov;
        int         nw;
        int         zf;
    } exp_t;

    typedef struct {
        int          idx;
        logic [63:0] val;
    } wexp_t;

    exp_t   exp_q[$];
    wexp_t  wq[$];
    int     checks   = 0;
    int     failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_load(input logic [8:0] wc, input logic [7:0] cs,
                               input logic ov, input int nw, input int zf);
        exp_t e;
        e.wc = wc; e.cs = cs; e.ov = ov; e.nw = nw; e.zf = zf;
        exp_q.push_back(e);
    endtask

    task automatic expect_word(input int idx, input logic [63:0] val);
        wexp_t w;
        w.idx = idx; w.val = val;
        wq.push_back(w);
    endtask

    // Monitor: on each rising done, pop the expected load and compare
    exp_t   m_e;
    wexp_t  m_w;
    logic   m_bad;
    logic   prev_done = 1'b0;
    always @(negedge clk) begin
        if (done && !prev_done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                m_e = exp_q.pop_front();
                chk("word_count", {55'd0, word_count}, {55'd0, m_e.wc});
                chk("checksum", {56'd0, checksum}, {56'd0, m_e.cs});
                chk("overflow", {63'd0, overflow}, {63'd0, m_e.ov});
                chk("cpu_rst_done", {63'd0, cpu_rst}, 64'd1);
                for (int k = 0; k < m_e.nw; k++) begin
                    if (wq.size() == 0) begin
                        chk("word_queue_underflow", 64'd1, 64'd0);
                    end else begin
                        m_w = wq.pop_front();
                        chk($sformatf("ex_data[%0d]", m_w.idx), ex_data[m_w.idx], m_w.val);
                    end
                end
                m_bad = 1'b0;
                for (int i = m_e.zf; i < 256; i++) begin
                    if (ex_data[i] !== 64'd0) m_bad = 1'b1;
                end
                chk("zero_tail", {63'd0, m_bad}, 64'd0);
            end
        end
        prev_done = done;
    end

    task automatic do_start();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("start_loading", {63'd0, loading}, 64'd1);
        chk("start_in_ready", {63'd0, in_ready}, 64'd1);
        chk("start_cpu_rst", {63'd0, cpu_rst}, 64'd0);
    endtask

    task automatic send(input logic [7:0] b, input logic last, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b0;
            in_byte  = 8'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        chk("beat_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        if (last) begin
            #1;
            chk("last_done", {63'd0, done}, 64'd1);
            chk("last_cpu_rst", {63'd0, cpu_rst}, 64'd1);
            chk("last_in_ready", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        chk({tag, "_cpu_rst"}, {63'd0, cpu_rst}, 64'd0);
        chk({tag, "_loading"}, {63'd0, loading}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_word_count"}, {55'd0, word_count}, 64'd0);
        chk({tag, "_checksum"}, {56'd0, checksum}, 64'd0);
        chk({tag, "_overflow"}, {63'd0, overflow}, 64'd0);
        chk({tag, "_ex_data_zero"}, {63'd0, |ex_data}, 64'd0);
    endtask

    // Stimulus: directed loads with hand-computed expectations
    initial begin
        rst      = 1'b0;
        start    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'hFF;
        in_last  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        @(negedge clk);
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;

        // Two-word image 0x01..0x10
        expect_load(9'd2, 8'h10, 1'b0, 2, 2);
        expect_word(0, 64'h0102030405060708);
        expect_word(1, 64'h090A0B0C0D0E0F10);
        do_start();
        for (int i = 1; i <= 16; i++) send(8'(i), (i == 16), 0);

        // Reload from DONE: previous image must be cleared
        expect_load(9'd1, 8'h55, 1'b0, 2, 1);
        expect_word(0, 64'h5500000000000000);
        expect_word(1, 64'h0);
        do_start();
        send(8'h55, 1'b1, 0);

        // Partial word with idle gaps and junk data
        expect_load(9'd1, 8'hDD, 1'b0, 1, 1);
        expect_word(0, 64'hAABBCC0000000000);
        do_start();
        send(8'hAA, 1'b0, 0);
        send(8'hBB, 1'b0, 2);
        send(8'hCC, 1'b1, 2);

        // Overflow: 2049 bytes, the last one is dropped
        expect_load(9'd256, 8'h00, 1'b1, 2, 256);
        expect_word(0, 64'h0001020304050607);
        expect_word(255, 64'hF8F9FAFBFCFDFEFF);
        do_start();
        for (int i = 0; i < 2049; i++) send(8'(i), (i == 2048), 0);

        // Reload after overflow: overflow flag must clear
        expect_load(9'd1, 8'h55, 1'b0, 2, 1);
        expect_word(0, 64'h5500000000000000);
        expect_word(255, 64'h0);
        do_start();
        send(8'h55, 1'b1, 0);

        // Reset in the middle of a load
        do_start();
        for (int i = 0; i < 5; i++) send(8'(8'h11 + i), 1'b0, 0);
        @(negedge clk);
        rst      = 1'b0;
        start    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h99;
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_state("midreset");
        @(negedge clk);
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_idle", {63'd0, loading}, 64'd0);

        expect_load(9'd1, 8'h03, 1'b0, 1, 1);
        expect_word(0, 64'hA1A2000000000000);
        do_start();
        send(8'hA1, 1'b0, 0);
        send(8'hA2, 1'b1, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
        chk("word_queue_drained", 64'(wq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/program_loader.md
# program_loader

Upstream stage of `cpu`: receives a program/data image as a byte stream over a valid/ready handshake and assembles it into the 256 x 64-bit `ex_data` array that `cpu` consumes. It holds the core in reset while loading and releases it once the image is complete. It also reports word count, an XOR checksum and a sticky overflow flag for host-side verification.

## Interface
- `WORDS`, 256, number of 64-bit entries in `ex_data`; word pointer/count width is $clog2(WORDS)+1 (9 at default).
- `WORD_BITS`, 64, bits per entry; must be a multiple of 8; bytes per word `BPW = WORD_BITS/8` (8 at default).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a new load; sampled only in IDLE or DONE.
- `in_byte`  in  8  stream byte.
- `in_valid`  in  1  `in_byte`/`in_last` valid.
- `in_last`  in  1  marks final byte of image.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `ex_data`  out  [0:WORDS-1][0:WORD_BITS-1]  assembled image, bit 0 = MSB; connects to `cpu.ex_data`.
- `cpu_rst`  out  1  active-low reset for `cpu`; 1 only in DONE.
- `loading`  out  1  state == LOAD.
- `done`  out  1  state == DONE.
- `word_count`  out  9  words written, including a trailing partial word.
- `checksum`  out  8  XOR of all stored bytes.
- `overflow`  out  1  sticky: a byte arrived after the array was full.

## Operation
- States: IDLE, LOAD, DONE. All outputs are registered or decoded from the state register only.
- Reset (`rst`=0 at an edge): state IDLE, all of `ex_data` = 0, byte index `bi` = 0, word pointer `wp` = 0, `word_count` = 0, `checksum` = 0, `overflow` = 0, `in_ready` = 0, `cpu_rst` = 0, `loading` = 0, `done` = 0.
- IDLE/DONE + `start`=1: clear `ex_data`, `bi`, `wp`, `word_count`, `checksum` and `overflow`, then go to LOAD. `start` is ignored in LOAD.
- LOAD: `in_ready` = 1. A beat is accepted when `in_valid` && `in_ready`.
  - Accepted byte with `wp` < WORDS: write it to `ex_data[wp][8*bi +: 8]`, so the first byte is most significant. Set `checksum ^= in_byte`.
  - If `bi` == BPW-1: set `bi` = 0, increment `wp` and `word_count`. Otherwise increment `bi`.
  - Accepted byte with `wp` == WORDS: drop it. `checksum` is unchanged; set `overflow` = 1.
  - Accepted beat with `in_last`=1: go to DONE. If the beat ended with `bi` != 0 (a partial word), increment `word_count` once more. Bytes not written in a partial word remain 0 because of the clear on `start`.
  - `in_last` on a dropped overflow byte still ends the load.
- DONE: `in_ready` = 0, `done` = 1, `cpu_rst` = 1. `ex_data` holds stable until the next `start` or reset.
- Beats with `in_valid` = 0 have no effect. `in_byte` and `in_last` are ignored unless the beat is accepted.

## Timing
- `start` sampled at edge N: from edge N onward `loading` = 1, `in_ready` = 1 and `cpu_rst` = 0. The first byte can be accepted at edge N+1.
- Throughput is one byte per cycle with no bubbles, including across word boundaries.
- A byte accepted at edge M is visible in `ex_data`, `checksum` and `word_count` after edge M.
- `in_last` accepted at edge M: after edge M, `in_ready` = 0, `done` = 1 and `cpu_rst` = 1. The producer sees `in_ready` drop in the cycle after its last beat.
- Restart from DONE: `cpu_rst` falls after the `start` edge. It stays high for no more cycles than DONE lasted.
- `rst` low at any edge, including mid-LOAD or simultaneous with `start` or `in_last`: reset wins, and all outputs take their reset values after that edge.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `in_valid`=1 and `start`=1. Every output is 0, `in_ready`=0, and `ex_data` is all zero.
- Two-word image: `start`, then bytes 0x01..0x10 back-to-back with `in_last` on 0x10. Expected:
  - `ex_data[0]` = 0x0102030405060708 and `ex_data[1]` = 0x090A0B0C0D0E0F10.
  - `word_count` = 2, `checksum` = 0x10.
  - `done`=1 and `cpu_rst`=1 the edge after the last beat; `ex_data[2..255]` = 0.
- Partial word with gaps: `start`, then AA, BB, CC (`in_last` on CC) with `in_valid` low for 2 cycles between beats, and junk `in_byte` values while `in_valid` is low. Expected `ex_data[0]` = 0xAABBCC0000000000, `word_count` = 1, `checksum` = 0xDD.
- Overflow: 2049 bytes, each byte = index mod 256, with `in_last` on byte 2049. Expected:
  - `word_count` = 256, `overflow` = 1, `done` = 1.
  - `ex_data[255]` = 0xF8F9FAFBFCFDFEFF.
  - The 2049th byte (0x00) is not stored.
  - `checksum` = 0x00 (XOR of 0..255 taken 8 times).
- Reload: after the two-word test completes, pulse `start`, then send byte 0x55 with `in_last`. Expected:
  - `cpu_rst` drops to 0 for the load and returns to 1 after it.
  - `ex_data[0]` = 0x5500000000000000 and `ex_data[1]` = 0, showing the clear on `start`.
  - `word_count` = 1, `overflow` = 0.
- Reset mid-load: after 5 accepted bytes, drive `rst`=0 for one edge. State returns to IDLE, all outputs are 0, and a subsequent `start` loads correctly from word 0, byte 0.
